// File: rtl/intr_sync_pkg.sv
// Shared constants and channel mode encoding for the multi-channel interrupt synchroniser.
package intr_sync_pkg;

    localparam int SYNC_STAGE_DEF = 3;
    localparam int STRETCH_DEF    = 2;
    localparam int OVF_CNT_W_DEF  = 4;

    typedef enum logic {
        MODE_EDGE  = 1'b0,
        MODE_LEVEL = 1'b1
    } mode_e;

endpackage

// File: rtl/intr_sync_chan.sv
// One interrupt channel: async-preset stretcher, synchroniser chain, edge detector, pend/ovf state.
// INTR_SYNC_OVF_CNT_EN adds a saturating per-channel overflow counter.
module intr_sync_chan
    import intr_sync_pkg::*;
#(
    parameter mode_e MODE       = MODE_EDGE,
    parameter int    SYNC_STAGE = SYNC_STAGE_DEF,
    parameter int    STRETCH    = STRETCH_DEF,
    parameter int    OVF_CNT_W  = OVF_CNT_W_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_in,
    input  logic i_ack,
    output logic o_pend,
    output logic o_pulse,
`ifdef INTR_SYNC_OVF_CNT_EN
    output logic [OVF_CNT_W-1:0] o_ovf_cnt,
`endif
    output logic o_ovf
);

    logic w_chain_in;
    logic w_sync;
    logic w_edge;
    logic w_ovf_evt;

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGE-1:0] r_chain;
    logic r_prev;
    logic r_pend;
    logic r_pulse;

    generate
        if (MODE == MODE_EDGE) begin : g_stretch
            logic [STRETCH-1:0] r_str;

            // Preset holds the event while the source is high, however briefly.
            always_ff @(posedge i_clk or posedge i_rst or posedge i_in) begin
                if (i_rst)
                    r_str <= '0;
                else if (i_in)
                    r_str <= '1;
                else
                    r_str <= {1'b0, r_str[STRETCH-1:1]};
            end

            assign w_chain_in = r_str[0];
        end else begin : g_direct
            assign w_chain_in = i_in;
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_chain <= '0;
        else
            r_chain <= {r_chain[SYNC_STAGE-2:0], w_chain_in};
    end

    assign w_sync    = r_chain[SYNC_STAGE-1];
    assign w_edge    = w_sync & ~r_prev;
    assign w_ovf_evt = (MODE == MODE_EDGE) & w_edge & r_pend & ~i_ack;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev  <= 1'b0;
            r_pend  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_prev <= w_sync;
            if (MODE == MODE_LEVEL) begin
                // Look one stage ahead so the strobe lines up with pend rising.
                r_pend  <= 1'b0;
                r_pulse <= r_chain[SYNC_STAGE-2] & ~w_sync;
            end else begin
                r_pend  <= w_edge | (r_pend & ~i_ack);
                r_pulse <= w_edge & (~r_pend | i_ack);
            end
        end
    end

`ifdef INTR_SYNC_OVF_CNT_EN
    logic [OVF_CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_ack || MODE == MODE_LEVEL)
            r_cnt <= '0;
        else if (w_ovf_evt && r_cnt != {OVF_CNT_W{1'b1}})
            r_cnt <= r_cnt + {{(OVF_CNT_W-1){1'b0}}, 1'b1};
    end

    assign o_ovf_cnt = r_cnt;
    assign o_ovf     = (r_cnt != '0);
`else
    logic r_ovf;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_ovf <= 1'b0;
        else if (i_ack || MODE == MODE_LEVEL)
            r_ovf <= 1'b0;
        else if (w_ovf_evt)
            r_ovf <= 1'b1;
    end

    assign o_ovf = r_ovf;
`endif

    assign o_pend  = (MODE == MODE_LEVEL) ? w_sync : r_pend;
    assign o_pulse = r_pulse;

endmodule

// File: rtl/intr_sync_multi.sv
// Multi-channel interrupt synchroniser into sync_clk with per-channel edge/level mode.
// INTR_SYNC_OVF_CNT_EN adds the intr_ovf_cnt port (per-channel saturating overflow count).
module intr_sync_multi
    import intr_sync_pkg::*;
#(
    parameter int               WIDTH      = 1,
    parameter int               SYNC_STAGE = SYNC_STAGE_DEF,
    parameter int               STRETCH    = STRETCH_DEF,
    parameter logic [WIDTH-1:0] LEVEL_MASK = {WIDTH{1'b0}},
    parameter int               OVF_CNT_W  = OVF_CNT_W_DEF
) (
    input  logic                       sync_clk,
    input  logic                       sync_rst,
    input  logic [WIDTH-1:0]           intr_in,
    input  logic [WIDTH-1:0]           intr_ack,
    output logic [WIDTH-1:0]           intr_pend,
    output logic [WIDTH-1:0]           intr_pulse,
`ifdef INTR_SYNC_OVF_CNT_EN
    output logic [WIDTH*OVF_CNT_W-1:0] intr_ovf_cnt,
`endif
    output logic [WIDTH-1:0]           intr_ovf
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
            intr_sync_chan #(
                .MODE       (LEVEL_MASK[gi] ? MODE_LEVEL : MODE_EDGE),
                .SYNC_STAGE (SYNC_STAGE),
                .STRETCH    (STRETCH),
                .OVF_CNT_W  (OVF_CNT_W)
            ) u_chan (
                .i_clk     (sync_clk),
                .i_rst     (sync_rst),
                .i_in      (intr_in[gi]),
                .i_ack     (intr_ack[gi]),
                .o_pend    (intr_pend[gi]),
                .o_pulse   (intr_pulse[gi]),
`ifdef INTR_SYNC_OVF_CNT_EN
                .o_ovf_cnt (intr_ovf_cnt[gi*OVF_CNT_W +: OVF_CNT_W]),
`endif
                .o_ovf     (intr_ovf[gi])
            );
        end
    endgenerate

endmodule
